fetch_decode_buffer: RTL and testbench

Small instruction queue between the fetch stage and the decode stage. Each fetched instruction is captured together with its PC and PC+4 in a DEPTH-entry FIFO. Fetch is back-pressured through a stall output when the queue is full. Decode sees a valid/stall handshake, and a taken branch or jump empties the queue through a flush input. The block replaces the plain IF/ID register and decouples fetch from decode-side hazard stalls.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/fd_fifo_ctrl.sv | 65 ++++++
 rtl/fetch_decode_buffer.sv | 80 ++++++++
 tb/tb_fetch_decode_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Types and constants shared by the fetch/decode boundary and later pipeline stages.
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam int ALEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [ALEN-1:0] pc;
        logic [ALEN-1:0] pcplus4;
    } fd_entry_t;

endpackage

// File: rtl/fd_fifo_ctrl.sv
// Pointer/occupancy control for the fetch-decode queue. Full and empty are
// derived from the occupancy count alone, so pointers may wrap freely.
module fd_fifo_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_f,
    input  logic             flush,
    input  logic             stall_d,
    output logic             stall_f,
    output logic             valid_d,
    output logic             enq,
    output logic             deq,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Flags depend only on registered state; stall_d never reaches stall_f.
    assign stall_f = (count_q == FULL_COUNT);
    assign valid_d = (count_q != '0);
    assign enq     = valid_f && !stall_f && !flush;
    assign deq     = valid_d && !stall_d && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/fetch_decode_buffer.sv
// Instruction queue replacing the IF/ID register: holds {instr, pc, pc+4}
// entries and presents the head to decode, masked to a NOP when empty.
module fetch_decode_buffer
    import pipeline_pkg::*;
#(
    parameter  int DATA_WIDTH    = XLEN,
    parameter  int ADDRESS_WIDTH = ALEN,
    parameter  int DEPTH         = 4,
    localparam int PTR_W         = $clog2(DEPTH),
    localparam int CNT_W         = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_f,
    input  logic [DATA_WIDTH-1:0]    instr_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_f,
    input  logic [ADDRESS_WIDTH-1:0] pcplus4_f,
    output logic                     stall_f,
    input  logic                     flush,
    input  logic                     stall_d,
    output logic                     valid_d,
    output logic [DATA_WIDTH-1:0]    instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pcplus4_d,
    output logic [CNT_W-1:0]         count
);

    logic             enq;
    logic             deq;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    fd_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .valid_f (valid_f),
        .flush   (flush),
        .stall_d (stall_d),
        .stall_f (stall_f),
        .valid_d (valid_d),
        .enq     (enq),
        .deq     (deq),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .count   (count)
    );

    // Storage is deliberately not reset; the output mask hides stale entries.
    fd_entry_t entries_q [DEPTH];
    fd_entry_t wr_entry;
    fd_entry_t head;

    always_comb begin
        wr_entry         = '0;
        wr_entry.instr   = instr_f;
        wr_entry.pc      = pc_f;
        wr_entry.pcplus4 = pcplus4_f;
    end

    always_ff @(posedge clk) begin
        if (enq) entries_q[wr_ptr] <= wr_entry;
    end

    // Asynchronous read so a new head is visible in the cycle it becomes head.
    assign head = entries_q[rd_ptr];

    always_comb begin
        instr_d   = DATA_WIDTH'(NOP_INSTR);
        pc_d      = '0;
        pcplus4_d = '0;
        if (valid_d) begin
            instr_d   = head.instr;
            pc_d      = head.pc;
            pcplus4_d = head.pcplus4;
        end
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed vector table, an
// asynchronous reset sequence, and random traffic against a queue model.
module tb_fetch_decode_buffer;
    import pipeline_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_f = 1'b0;
    logic [31:0] instr_f = '0;
    logic [31:0] pc_f = '0;
    logic [31:0] pcplus4_f = '0;
    logic        stall_f;
    logic        flush = 1'b0;
    logic        stall_d = 1'b0;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    fetch_decode_buffer #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .DEPTH         (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_f   (valid_f),
        .instr_f   (instr_f),
        .pc_f      (pc_f),
        .pcplus4_f (pcplus4_f),
        .stall_f   (stall_f),
        .flush     (flush),
        .stall_d   (stall_d),
        .valid_d   (valid_d),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pcplus4_d (pcplus4_d),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vf;
        logic [31:0] instr;
        logic        sd;
        logic        fl;
        logic [2:0]  exp_count;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pc_of(input logic [31:0] ins);
        return {26'd0, ins[3:0], 2'b00};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] e_cnt, input logic e_vld,
                                 input logic [31:0] e_ins, input logic [31:0] e_pc,
                                 input logic [31:0] e_pc4, input logic e_stall);
        check({tag, ".count"},     64'(count),     64'(e_cnt));
        check({tag, ".valid_d"},   64'(valid_d),   64'(e_vld));
        check({tag, ".instr_d"},   64'(instr_d),   64'(e_ins));
        check({tag, ".pc_d"},      64'(pc_d),      64'(e_pc));
        check({tag, ".pcplus4_d"}, 64'(pcplus4_d), 64'(e_pc4));
        check({tag, ".stall_f"},   64'(stall_f),   64'(e_stall));
    endtask

    task automatic drive(input logic vf, input logic [31:0] ins, input logic sd, input logic fl);
        valid_f   = vf;
        instr_f   = ins;
        pc_f      = pc_of(ins);
        pcplus4_f = pc_of(ins) + 32'd4;
        stall_d   = sd;
        flush     = fl;
    endtask

    task automatic step(input logic vf, input logic [31:0] ins, input logic sd, input logic fl);
        drive(vf, ins, sd, fl);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic vf, input logic [31:0] ins, input logic sd, input logic fl,
                                input logic [2:0] c, input logic v, input logic [31:0] ei, input logic st);
        vec_t r;
        r.vf = vf; r.instr = ins; r.sd = sd; r.fl = fl;
        r.exp_count = c; r.exp_valid = v; r.exp_instr = ei; r.exp_stall = st;
        vecs.push_back(r);
    endfunction

    fd_entry_t model_q[$];

    initial begin
        // Fill to full with decode stalled; fifth instruction must bounce.
        add(1, 32'hA0, 1, 0, 3'd1, 1, 32'hA0, 0);
        add(1, 32'hA1, 1, 0, 3'd2, 1, 32'hA0, 0);
        add(1, 32'hA2, 1, 0, 3'd3, 1, 32'hA0, 0);
        add(1, 32'hA3, 1, 0, 3'd4, 1, 32'hA0, 1);
        add(1, 32'hA4, 1, 0, 3'd4, 1, 32'hA0, 1);
        // Drain with fetch holding A4 until it is taken; pointers wrap.
        add(1, 32'hA4, 0, 0, 3'd3, 1, 32'hA1, 0);
        add(1, 32'hA4, 0, 0, 3'd3, 1, 32'hA2, 0);
        add(0, 32'h00, 0, 0, 3'd2, 1, 32'hA3, 0);
        add(0, 32'h00, 0, 0, 3'd1, 1, 32'hA4, 0);
        add(0, 32'h00, 0, 0, 3'd0, 0, NOP,    0);
        add(0, 32'h00, 0, 0, 3'd0, 0, NOP,    0);
        // Simultaneous enqueue and dequeue at occupancy 2.
        add(1, 32'hB0, 1, 0, 3'd1, 1, 32'hB0, 0);
        add(1, 32'hB1, 1, 0, 3'd2, 1, 32'hB0, 0);
        add(1, 32'hB2, 0, 0, 3'd2, 1, 32'hB1, 0);
        add(1, 32'hB3, 0, 0, 3'd2, 1, 32'hB2, 0);
        add(1, 32'hB4, 0, 0, 3'd2, 1, 32'hB3, 0);
        add(1, 32'hB5, 0, 0, 3'd2, 1, 32'hB4, 0);
        add(1, 32'hB6, 0, 0, 3'd2, 1, 32'hB5, 0);
        // Flush at occupancy 3 with fetch presenting B8.
        add(1, 32'hB7, 1, 0, 3'd3, 1, 32'hB5, 0);
        add(1, 32'hB8, 0, 1, 3'd0, 0, NOP,    0);
        add(0, 32'h00, 0, 0, 3'd0, 0, NOP,    0);
        add(0, 32'h00, 1, 0, 3'd0, 0, NOP,    0);
        // Flush while full.
        add(1, 32'hC0, 1, 0, 3'd1, 1, 32'hC0, 0);
        add(1, 32'hC1, 1, 0, 3'd2, 1, 32'hC0, 0);
        add(1, 32'hC2, 1, 0, 3'd3, 1, 32'hC0, 0);
        add(1, 32'hC3, 1, 0, 3'd4, 1, 32'hC0, 1);
        add(1, 32'hC4, 1, 1, 3'd0, 0, NOP,    0);
        add(0, 32'h00, 0, 0, 3'd0, 0, NOP,    0);

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_held", 3'd0, 0, NOP, 32'd0, 32'd0, 0);
        rst = 1'b1;
        step(0, 32'h0, 0, 0);
        check_outputs("idle", 3'd0, 0, NOP, 32'd0, 32'd0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].vf, vecs[i].instr, vecs[i].sd, vecs[i].fl);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_valid,
                          vecs[i].exp_instr,
                          vecs[i].exp_valid ? pc_of(vecs[i].exp_instr) : 32'd0,
                          vecs[i].exp_valid ? pc_of(vecs[i].exp_instr) + 32'd4 : 32'd0,
                          vecs[i].exp_stall);
        end

        // Asynchronous reset mid-cycle at occupancy 3.
        step(1, 32'hD0, 1, 0);
        step(1, 32'hD1, 1, 0);
        step(1, 32'hD2, 1, 0);
        check_outputs("pre_rst", 3'd3, 1, 32'hD0, pc_of(32'hD0), pc_of(32'hD0) + 32'd4, 0);
        drive(0, 32'h0, 1, 0);
        #3;
        rst = 1'b0;
        #1;
        check_outputs("async_rst", 3'd0, 0, NOP, 32'd0, 32'd0, 0);
        @(posedge clk);
        #1;
        check_outputs("rst_low_edge", 3'd0, 0, NOP, 32'd0, 32'd0, 0);
        rst = 1'b1;
        drive(1, 32'hE0, 1, 0);
        #0;
        check_outputs("post_rst_pre_edge", 3'd0, 0, NOP, 32'd0, 32'd0, 0);
        @(posedge clk);
        #1;
        check_outputs("post_rst_enq", 3'd1, 1, 32'hE0, pc_of(32'hE0), pc_of(32'hE0) + 32'd4, 0);
        step(0, 32'h0, 0, 0);
        check_outputs("post_rst_drain", 3'd0, 0, NOP, 32'd0, 32'd0, 0);

        // Random traffic against a queue model; fetch holds its instruction while refused.
        begin
            logic [31:0] cur_instr;
            logic        cur_vf;
            logic        held;
            cur_instr = $urandom;
            cur_vf    = 1'b1;
            held      = 1'b0;
            for (int n = 0; n < 400; n++) begin
                logic sd, fl, full, acc;
                fd_entry_t e, h;
                if (!held) begin
                    cur_vf    = ($urandom_range(3) != 0);
                    cur_instr = $urandom;
                end
                sd = ($urandom_range(2) == 0);
                fl = ($urandom_range(15) == 0);
                full = (model_q.size() == DEPTH);
                acc  = cur_vf && !full && !fl;
                drive(cur_vf, cur_instr, sd, fl);
                @(posedge clk);
                #1;
                if (fl) begin
                    model_q.delete();
                end else begin
                    if (model_q.size() != 0 && !sd) void'(model_q.pop_front());
                    if (acc) begin
                        e.instr = cur_instr;
                        e.pc = pc_of(cur_instr);
                        e.pcplus4 = pc_of(cur_instr) + 32'd4;
                        model_q.push_back(e);
                    end
                end
                held = cur_vf && !acc && !fl;
                if (model_q.size() != 0) begin
                    h = model_q[0];
                    check_outputs($sformatf("rnd%0d", n), 3'(model_q.size()), 1, h.instr, h.pc, h.pcplus4,
                                  model_q.size() == DEPTH);
                end else begin
                    check_outputs($sformatf("rnd%0d", n), 3'd0, 0, NOP, 32'd0, 32'd0, 0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
